// File: rtl/flag_watchdog_pkg.sv
// Shared types and constants for the flag watchdog.
//   wd_state_e      : watchdog FSM encoding, exported on the wd_state port
//   DEFAULT_TIMEOUT : integration value for the timeout port
//   sat_inc8        : saturating 8-bit increment used by the trip counter
package flag_watchdog_pkg;

  typedef enum logic [1:0] {
    WD_ARMED   = 2'd0,
    WD_FIRE    = 2'd1,
    WD_HOLDOFF = 2'd2,
    WD_LATCHED = 2'd3
  } wd_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1_600_000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/flag_watchdog_mc.sv
// Multi-channel watchdog on transceiver receive-status flags.
// Each channel counts cycles of a stuck-high flag (mode 0) or of flag
// inactivity (mode 1); reaching timeout trips the watchdog, which drives an
// active-low reset pulse (or a latched reset) to the receive logic.
//   clk, rst   : clock, asynchronous active-low reset
//   flag_in    : raw flags, asynchronous to clk
//   ch_en      : per-channel enable (0 holds the counter at 0)
//   ch_mode    : 0 stuck-high detect, 1 inactivity detect
//   timeout    : trip threshold in cycles, 0 disables all channels
//   clr_cause  : one-cycle pulse clearing cause and trip_cnt
//   rst_out    : active-low reset to the receive logic (registered)
//   cause      : sticky record of channels that tripped
//   trip_cnt   : saturating trip event count
//   wd_state   : FSM state (0 ARMED, 1 FIRE, 2 HOLDOFF, 3 LATCHED)
//
// Handshake: there is no valid/ready flow; clr_cause is a plain one-cycle
// strobe sampled on the next rising edge, and trips are one-cycle internal
// pulses consumed only while ARMED.
module flag_watchdog_mc
  import flag_watchdog_pkg::*;
#(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned RST_PULSE_CYC = 16,
  parameter int unsigned HOLDOFF_CYC   = 1024,
  parameter int unsigned LATCH         = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  flag_in,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  ch_mode,
  input  logic [CNT_W-1:0] timeout,
  input  logic             clr_cause,
  output logic             rst_out,
  output logic [N_CH-1:0]  cause,
  output logic [7:0]       trip_cnt,
  output logic [1:0]       wd_state
);

  localparam int unsigned DLY_MAX = (RST_PULSE_CYC > HOLDOFF_CYC) ? RST_PULSE_CYC : HOLDOFF_CYC;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] PULSE_LD = DLY_W'(RST_PULSE_CYC - 1);
  localparam logic [DLY_W-1:0] HOLD_LD  = DLY_W'(HOLDOFF_CYC - 1);

  wd_state_e         state;
  logic [DLY_W-1:0]  dly;
  logic [N_CH-1:0]   flag_s;
  logic [N_CH-1:0]   flag_q;
  logic [N_CH-1:0]   edge_v;
  logic [N_CH-1:0]   trip_q;
  logic              global_hold;

  // Counters only run while ARMED with a non-zero threshold.
  assign global_hold = (state != WD_ARMED) || (timeout == '0);
  assign edge_v      = flag_s ^ flag_q;
  assign wd_state    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= '0;
    else      flag_q <= flag_s;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic             run;
    logic             hold;
    logic             trip_r;

    sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (flag_in[g]),
      .q   (flag_s[g])
    );

    assign hold = global_hold || !ch_en[g];
    // Condition that keeps the episode alive: flag high, or no edge.
    assign run  = ch_mode[g] ? !edge_v[g] : flag_s[g];

    always_comb begin
      cnt_nxt = '0;
      if (!hold && run) begin
        // Hold at (or above, after a lowered timeout) the threshold.
        if (cnt_r >= timeout) cnt_nxt = cnt_r;
        else                  cnt_nxt = cnt_r + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r  <= '0;
        trip_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_nxt;
        // Only the transition onto timeout trips; a held or overshooting
        // counter never re-trips until it clears.
        trip_r <= !hold && (cnt_nxt == timeout) && (cnt_r != timeout);
      end
    end

    assign trip_q[g] = trip_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WD_ARMED;
      rst_out  <= 1'b1;
      dly      <= '0;
      cause    <= '0;
      trip_cnt <= 8'd0;
    end else begin
      if (clr_cause) begin
        cause    <= '0;
        trip_cnt <= 8'd0;
      end
      case (state)
        WD_ARMED: begin
          if (|trip_q) begin
            state   <= WD_FIRE;
            rst_out <= 1'b0;
            dly     <= PULSE_LD;
            // A coincident clear loses to the trip.
            cause    <= clr_cause ? trip_q : (cause | trip_q);
            trip_cnt <= clr_cause ? 8'd1 : sat_inc8(trip_cnt);
          end
        end
        WD_FIRE: begin
          if (dly == '0) begin
            if (LATCH != 0) begin
              state <= WD_LATCHED;
            end else begin
              state   <= WD_HOLDOFF;
              rst_out <= 1'b1;
              dly     <= HOLD_LD;
            end
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        WD_HOLDOFF: begin
          if (dly == '0) state <= WD_ARMED;
          else           dly   <= dly - DLY_W'(1);
        end
        WD_LATCHED: begin
          rst_out <= 1'b0;
        end
        default: begin
          state   <= WD_ARMED;
          rst_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_watchdog_mc.sv
// Directed bench for flag_watchdog_mc: a pulse-mode instance (LATCH=0) and a
// latched instance (LATCH=1) share all stimulus. HOLDOFF_CYC is shortened so
// the saturation run stays short.
module tb_flag_watchdog_mc;

  logic        clk;
  logic        rst;
  logic [1:0]  flag_in;
  logic [1:0]  ch_en;
  logic [1:0]  ch_mode;
  logic [23:0] timeout;
  logic        clr_cause;

  logic        rst_out,  rst_out_l;
  logic [1:0]  cause,    cause_l;
  logic [7:0]  trip_cnt, trip_cnt_l;
  logic [1:0]  wd_state, wd_state_l;

  int n_checks = 0;
  int n_fail   = 0;

  flag_watchdog_mc #(
    .N_CH(2), .CNT_W(24), .RST_PULSE_CYC(16), .HOLDOFF_CYC(20), .LATCH(0)
  ) u_dut (
    .clk(clk), .rst(rst), .flag_in(flag_in), .ch_en(ch_en), .ch_mode(ch_mode),
    .timeout(timeout), .clr_cause(clr_cause), .rst_out(rst_out), .cause(cause),
    .trip_cnt(trip_cnt), .wd_state(wd_state)
  );

  flag_watchdog_mc #(
    .N_CH(2), .CNT_W(24), .RST_PULSE_CYC(16), .HOLDOFF_CYC(20), .LATCH(1)
  ) u_dut_l (
    .clk(clk), .rst(rst), .flag_in(flag_in), .ch_en(ch_en), .ch_mode(ch_mode),
    .timeout(timeout), .clr_cause(clr_cause), .rst_out(rst_out_l), .cause(cause_l),
    .trip_cnt(trip_cnt_l), .wd_state(wd_state_l)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n cycles and report whether rst_out was seen low.
  task automatic run_watch(input int n, output logic low_seen);
    low_seen = 1'b0;
    repeat (n) begin
      tick(1);
      if (!rst_out) low_seen = 1'b1;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc, input string tag);
    int k;
    k = 0;
    while (wd_state !== st && k < max_cyc) begin
      tick(1);
      k++;
    end
    check(tag, {30'd0, wd_state}, {30'd0, st});
  endtask

  task automatic pulse_clr();
    clr_cause = 1'b1;
    tick(1);
    clr_cause = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic low, low_acc;
    int   n_trip;

    rst = 1'b0; flag_in = '0; ch_en = '0; ch_mode = '0;
    timeout = '0; clr_cause = 1'b0;
    tick(3);
    check("rst_rst_out",  {31'd0, rst_out}, 32'd1);
    check("rst_cause",    {30'd0, cause}, 32'd0);
    check("rst_trip_cnt", {24'd0, trip_cnt}, 32'd0);
    check("rst_state",    {30'd0, wd_state}, 32'd0);
    rst = 1'b1;
    tick(2);

    // ---- T1: stuck-high on ch0, timeout 10 ----
    timeout = 24'd10; ch_en = 2'b01; ch_mode = 2'b00;
    tick(2);
    flag_in = 2'b01;
    tick(12);
    check("t1_pre_rst_out", {31'd0, rst_out}, 32'd1);
    check("t1_pre_state",   {30'd0, wd_state}, 32'd0);
    tick(1);
    check("t1_fire_rst_out",  {31'd0, rst_out}, 32'd0);
    check("t1_fire_state",    {30'd0, wd_state}, 32'd1);
    check("t1_cause",         {30'd0, cause}, 32'd1);
    check("t1_trip_cnt",      {24'd0, trip_cnt}, 32'd1);
    check("t1_l_fire_rst_out", {31'd0, rst_out_l}, 32'd0);
    tick(7);
    flag_in = 2'b00;
    tick(8);
    check("t1_last_low", {31'd0, rst_out}, 32'd0);
    tick(1);
    check("t1_pulse_end",    {31'd0, rst_out}, 32'd1);
    check("t1_holdoff",      {30'd0, wd_state}, 32'd2);
    check("t1_l_latched",    {30'd0, wd_state_l}, 32'd3);
    check("t1_l_rst_out",    {31'd0, rst_out_l}, 32'd0);
    tick(19);
    check("t1_holdoff_last", {30'd0, wd_state}, 32'd2);
    tick(1);
    check("t1_rearmed",      {30'd0, wd_state}, 32'd0);
    run_watch(30, low);
    check("t1_no_retrip",    {31'd0, low}, 32'd0);
    check("t1_trip_cnt_hold", {24'd0, trip_cnt}, 32'd1);
    pulse_clr();
    check("clr_cause",      {30'd0, cause}, 32'd0);
    check("clr_trip_cnt",   {24'd0, trip_cnt}, 32'd0);
    check("clr_l_cause",    {30'd0, cause_l}, 32'd0);
    check("clr_l_trip_cnt", {24'd0, trip_cnt_l}, 32'd0);
    check("clr_l_state",    {30'd0, wd_state_l}, 32'd3);
    check("clr_l_rst_out",  {31'd0, rst_out_l}, 32'd0);

    // ---- asynchronous reset out of LATCHED ----
    #3;
    rst = 1'b0;
    #1;
    check("async_l_rst_out", {31'd0, rst_out_l}, 32'd1);
    check("async_l_state",   {30'd0, wd_state_l}, 32'd0);
    #2;
    rst = 1'b1;
    tick(2);

    // ---- T2: 9 high, 1 low, 9 high -> no trip ----
    flag_in = 2'b01;
    run_watch(9, low);  low_acc = low;
    flag_in = 2'b00;
    run_watch(1, low);  low_acc |= low;
    flag_in = 2'b01;
    run_watch(9, low);  low_acc |= low;
    flag_in = 2'b00;
    run_watch(30, low); low_acc |= low;
    check("t2_no_trip", {31'd0, low_acc}, 32'd0);
    check("t2_cause",   {30'd0, cause}, 32'd0);

    // ---- T3: inactivity on ch1, timeout 8 ----
    timeout = 24'd8; ch_en = 2'b10; ch_mode = 2'b10;
    low_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flag_in[1] = ~flag_in[1];
      run_watch(5, low);
      low_acc |= low;
    end
    flag_in[1] = ~flag_in[1];
    run_watch(11, low);
    low_acc |= low;
    check("t3_no_early_trip", {31'd0, low_acc}, 32'd0);
    tick(1);
    check("t3_fire_rst_out", {31'd0, rst_out}, 32'd0);
    check("t3_cause",        {30'd0, cause}, 32'd2);
    ch_en = 2'b00;
    wait_state(2'd0, 100, "t3_rearm");
    pulse_clr();

    // ---- T4: both channels trip together ----
    timeout = 24'd10; ch_en = 2'b11; ch_mode = 2'b00;
    tick(2);
    flag_in = 2'b11;
    tick(13);
    check("t4_state",    {30'd0, wd_state}, 32'd1);
    check("t4_cause",    {30'd0, cause}, 32'd3);
    check("t4_trip_cnt", {24'd0, trip_cnt}, 32'd1);
    tick(17);
    flag_in = 2'b00;
    tick(18);
    check("t4_holdoff",      {30'd0, wd_state}, 32'd2);
    check("t4_holdoff_cnt",  {24'd0, trip_cnt}, 32'd1);
    tick(1);
    check("t4_rearmed",      {30'd0, wd_state}, 32'd0);
    run_watch(20, low);
    check("t4_no_retrip",    {31'd0, low}, 32'd0);
    check("t4_trip_cnt_end", {24'd0, trip_cnt}, 32'd1);
    pulse_clr();

    // ---- T5: timeout lowered below a running count ----
    timeout = 24'd20; ch_en = 2'b01; ch_mode = 2'b00;
    flag_in = 2'b01;
    tick(15);
    timeout = 24'd10;
    run_watch(25, low);
    check("t5_overshoot_no_trip", {31'd0, low}, 32'd0);
    flag_in = 2'b00;
    tick(4);
    flag_in = 2'b01;
    tick(12);
    check("t5_pre_trip", {31'd0, rst_out}, 32'd1);
    tick(1);
    check("t5_trip",     {31'd0, rst_out}, 32'd0);
    flag_in = 2'b00;
    wait_state(2'd0, 100, "t5_rearm");
    pulse_clr();

    // ---- T6: disabled channel and timeout 0 ----
    ch_en = 2'b00; timeout = 24'd10;
    flag_in = 2'b01;
    run_watch(1000, low);
    check("t6_ch_dis_no_trip", {31'd0, low}, 32'd0);
    ch_en = 2'b01; timeout = 24'd0;
    run_watch(1000, low);
    check("t6_to0_no_trip",   {31'd0, low}, 32'd0);
    check("t6_trip_cnt",      {24'd0, trip_cnt}, 32'd0);
    flag_in = 2'b00;
    tick(3);

    // ---- T7: 300 trips, trip_cnt saturates at 255 ----
    timeout = 24'd2;
    flag_in = 2'b01;
    n_trip = 0;
    while (n_trip < 300) begin
      wait_state(2'd1, 100, "t7_fire");
      n_trip++;
      if (n_trip == 1 || n_trip == 254 || n_trip == 255 || n_trip == 256 || n_trip == 300)
        check("t7_trip_cnt", {24'd0, trip_cnt}, (n_trip > 255) ? 32'd255 : n_trip);
      wait_state(2'd0, 100, "t7_rearm");
    end
    // Now at the first ARMED cycle: trip lands two edges later, FIRE on the third.
    tick(2);
    clr_cause = 1'b1;
    tick(1);
    clr_cause = 1'b0;
    check("t7_clr_vs_trip_state", {30'd0, wd_state}, 32'd1);
    check("t7_clr_vs_trip_cnt",   {24'd0, trip_cnt}, 32'd1);
    check("t7_clr_vs_trip_cause", {30'd0, cause}, 32'd1);
    flag_in = 2'b00;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_watchdog_mc.md
Name: flag_watchdog_mc

Overview:
Parametrised multi-channel watchdog for receive-status flags from the TTC transceivers. Each channel detects either a flag stuck asserted (mode 0) or a flag with no activity (mode 1) for a programmable number of clock cycles. On a timeout it drives an active-low reset pulse, or a latched reset, to the downstream receive logic. It records which channels caused the trip and counts trip events.

Parameters:
N_CH, 2, number of monitored flag channels (1..16)
CNT_W, 24, width of per-channel counters and of the timeout port
RST_PULSE_CYC, 16, cycles rst_out is held low per trip (>=1)
HOLDOFF_CYC, 1024, cycles after a pulse during which trips are ignored (>=1)
LATCH, 0, 1 = rst_out stays low after a trip until rst; 0 = pulse then re-arm

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
flag_in  in  N_CH  raw receive flags, asynchronous to clk
ch_en  in  N_CH  per-channel enable; 0 = counter held at 0, channel never trips
ch_mode  in  N_CH  0 = stuck-high detect; 1 = inactivity detect (no edge)
timeout  in  CNT_W  trip threshold in cycles, quasi-static; 0 = all channels disabled
clr_cause  in  1  single-cycle pulse that clears cause and trip_cnt
rst_out  out  1  active-low reset to receive logic
cause  out  N_CH  sticky per-channel trip record
trip_cnt  out  8  saturating count of trips
wd_state  out  2  0 ARMED, 1 FIRE, 2 HOLDOFF, 3 LATCHED

Behaviour:
- Reset (rst=0): rst_out=1, cause=0, trip_cnt=0, wd_state=ARMED, all counters and sync flops cleared.
- Input path: each flag_in passes a 2-FF synchronizer; flag_s is the synchronized value. A registered copy flag_q of flag_s provides edge detection (edge = flag_s ^ flag_q).
- Counter i in ARMED:
  - Mode 0: increments while flag_s=1; clears to 0 when flag_s=0.
  - Mode 1: clears to 0 on edge; increments otherwise.
- Counter saturation: counter i saturates at timeout and holds there while its condition persists.
- Trip generation: trip_i asserts for exactly one cycle, in the cycle the counter transitions to value == timeout. Only one trip is generated per episode; the counter must clear before channel i can trip again.
- Counter hold: counters are held at 0 when ch_en[i]=0, when timeout=0, and in FIRE, HOLDOFF and LATCHED.
- Example latency: with mode 0 and flag_in rising at cycle 0, trip occurs at cycle 2 + timeout. rst_out falls the following cycle (registered).
- FSM:
  - ARMED: any trip -> FIRE. In the same edge: cause |= trip vector (all simultaneous trips recorded), trip_cnt += 1 (saturating at 255), pulse counter loaded.
  - FIRE: rst_out=0 for exactly RST_PULSE_CYC cycles. Then -> LATCHED if LATCH=1, else -> HOLDOFF.
  - HOLDOFF: rst_out=1 for HOLDOFF_CYC cycles, then -> ARMED with counters starting from 0.
  - LATCHED: rst_out=0 until rst asserts; absorbing state.
- clr_cause: clears cause and trip_cnt the next edge in any state. If it coincides with a trip, the trip wins: cause = new trip vector, trip_cnt = 1.
- Runtime changes: changing timeout or ch_mode while counting takes effect immediately. If a counter already exceeds a newly lowered timeout, the counter does not trip; it clears on the next clearing condition.
- Reset mid-pulse or in LATCHED returns to ARMED with rst_out=1 asynchronously.

Decomposition:
- Package flag_watchdog_pkg: wd_state enum (ARMED, FIRE, HOLDOFF, LATCHED) and the constant DEFAULT_TIMEOUT = 1_600_000 used as the integration value for timeout.
- Sub-module: sync_2ff (1-bit two-flop synchronizer with async active-low reset), instantiated N_CH times via generate.

Test Plan:
- timeout=10, ch0 mode 0, flag_in[0] high for 20 cycles -> rst_out low 13 cycles after the rise for 16 cycles; cause=01; trip_cnt=1; wd_state sequence ARMED->FIRE->HOLDOFF->ARMED.
- timeout=10, flag_in[0] high 9 cycles, low 1 cycle, high 9 cycles -> no trip, rst_out stays 1, cause=00.
- ch1 mode 1, timeout=8, flag_in[1] toggling every 5 cycles then held constant -> trip exactly 8 cycles after the last synchronized edge; cause=10.
- Both channels reach timeout in the same cycle -> single FIRE; cause=11; trip_cnt=1. A second trip during HOLDOFF is ignored and trip_cnt remains 1.
- LATCH=1, trip, then clr_cause pulse -> rst_out stays 0 and wd_state=3; cause=0; trip_cnt=0. Pulse rst low -> rst_out=1 immediately; wd_state=0.
- ch_en[0]=0 or timeout=0 with flag_in[0] high 1000 cycles -> no trip. Also 300 trips forced -> trip_cnt saturates at 255.
